// File: rtl/rocc_cmd_issuer.sv
// ---------------------------------------------------------------------------
// rocc_cmd_issuer
//
// Core-side initiator for a RoCC command/response port set.
//
// Data path:
//   * A single-entry command register accepts host requests and presents
//     them to the accelerator until the command fires.
//   * A 32-entry scoreboard tracks destination registers of commands that
//     expect a response (xd=1).
//   * Each matching response becomes a registered, one-cycle writeback.
//
// Optional feature (macro ROCC_ISSUER_TIMEOUT_EN):
//   * When defined, a response watchdog raises the sticky o_timeout flag
//     after TIMEOUT_CYCLES cycles without a response while commands are
//     outstanding.
//   * When undefined, o_timeout is tied low and the port list is unchanged.
//
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   i_req_* / o_req_ready        host request channel
//   o_cmd_* / i_cmd_ready        accelerator command channel (registered fields)
//   i_busy                       accelerator busy, feeds o_idle
//   i_resp_* / o_resp_ready      accelerator response channel
//   o_wb_valid/o_wb_rd/o_wb_data one-cycle writeback of response data
//   o_outstanding                in-flight xd=1 command count
//   o_idle                       nothing held, nothing in flight, not busy
//   o_err_unexpected, o_timeout  sticky error flags, cleared by reset only
// ---------------------------------------------------------------------------
module rocc_cmd_issuer #(
  parameter logic [6:0]  OPCODE          = 7'b0001011,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [6:0]  i_req_funct,
  input  logic [63:0] i_req_rs1,
  input  logic [63:0] i_req_rs2,
  input  logic        i_req_xs1,
  input  logic        i_req_xs2,
  input  logic [4:0]  i_req_rd,
  input  logic        i_req_xd,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic [6:0]  o_cmd_bits_inst_opcode,
  output logic [6:0]  o_cmd_bits_inst_funct,
  output logic [63:0] o_cmd_bits_rs1,
  output logic [63:0] o_cmd_bits_rs2,
  output logic        o_cmd_bits_inst_xs1,
  output logic        o_cmd_bits_inst_xs2,
  output logic [4:0]  o_cmd_bits_inst_rd,
  output logic        o_cmd_bits_inst_xd,
  output logic        o_cmd_fire,
  input  logic        i_busy,
  input  logic        i_resp_valid,
  output logic        o_resp_ready,
  input  logic [4:0]  i_resp_bits_rd,
  input  logic [63:0] i_resp_bits_data,
  output logic        o_resp_fire,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [63:0] o_wb_data,
  output logic [4:0]  o_outstanding,
  output logic        o_idle,
  output logic        o_err_unexpected,
  output logic        o_timeout
);

  localparam logic [4:0] CNT_MAX = 5'(MAX_OUTSTANDING);

  logic        cmd_valid_q, cmd_valid_d;
  logic [6:0]  funct_q;
  logic [63:0] rs1_q, rs2_q;
  logic        xs1_q, xs2_q, xd_q;
  logic [4:0]  rd_q;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [63:0] wb_data_q;

  logic hazard_s, req_ready_s, req_fire_s, cmd_fire_s, resp_fire_s, resp_hit_s;

  // Handshake decode; hazard uses registered scoreboard state only, so a
  // response clearing a bit unblocks the request one cycle later.
  always_comb begin
    hazard_s    = i_req_xd && (pending_q[i_req_rd] || (count_q == CNT_MAX));
    req_ready_s = !reset && !cmd_valid_q && !hazard_s;
    req_fire_s  = i_req_valid && req_ready_s;
    cmd_fire_s  = cmd_valid_q && i_cmd_ready;
    resp_fire_s = i_resp_valid && !reset;
    resp_hit_s  = pending_q[i_resp_bits_rd];
  end

  // Next-state for command valid, scoreboard, in-flight count and error flag.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    pending_d   = pending_q;
    count_d     = count_q;
    err_d       = err_q;
    if (req_fire_s) begin
      cmd_valid_d = 1'b1;
    end else if (cmd_fire_s) begin
      cmd_valid_d = 1'b0;
    end else begin
      cmd_valid_d = cmd_valid_q;
    end
    // Hazard guarantees the fired rd differs from any matching response rd.
    if (cmd_fire_s && xd_q) begin
      pending_d[rd_q] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    if (resp_fire_s && resp_hit_s) begin
      pending_d[i_resp_bits_rd] = 1'b0;
    end else if (resp_fire_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    case ({cmd_fire_s && xd_q, resp_fire_s && resp_hit_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Command register, scoreboard, count, error flag and writeback stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      funct_q     <= 7'd0;
      rs1_q       <= 64'd0;
      rs2_q       <= 64'd0;
      xs1_q       <= 1'b0;
      xs2_q       <= 1'b0;
      rd_q        <= 5'd0;
      xd_q        <= 1'b0;
      pending_q   <= 32'd0;
      count_q     <= 5'd0;
      err_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 64'd0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      err_q       <= err_d;
      wb_valid_q  <= resp_fire_s && resp_hit_s;
      if (req_fire_s) begin
        funct_q <= i_req_funct;
        rs1_q   <= i_req_rs1;
        rs2_q   <= i_req_rs2;
        xs1_q   <= i_req_xs1;
        xs2_q   <= i_req_xs2;
        rd_q    <= i_req_rd;
        xd_q    <= i_req_xd;
      end
      if (resp_fire_s && resp_hit_s) begin
        wb_rd_q   <= i_resp_bits_rd;
        wb_data_q <= i_resp_bits_data;
      end
    end
  end

`ifdef ROCC_ISSUER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  // Watchdog: restarts on any response or when nothing is in flight,
  // saturates at the limit.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (resp_fire_s || (count_q == 5'd0)) begin
      wd_d = '0;
    end else if (wd_q != WD_LIMIT) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end
    if (wd_q == WD_LIMIT) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Watchdog state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_req_ready            = req_ready_s;
  assign o_cmd_valid            = cmd_valid_q;
  assign o_cmd_bits_inst_opcode = OPCODE;
  assign o_cmd_bits_inst_funct  = funct_q;
  assign o_cmd_bits_rs1         = rs1_q;
  assign o_cmd_bits_rs2         = rs2_q;
  assign o_cmd_bits_inst_xs1    = xs1_q;
  assign o_cmd_bits_inst_xs2    = xs2_q;
  assign o_cmd_bits_inst_rd     = rd_q;
  assign o_cmd_bits_inst_xd     = xd_q;
  assign o_cmd_fire             = cmd_fire_s;
  assign o_resp_ready           = !reset;
  assign o_resp_fire            = resp_fire_s;
  assign o_wb_valid             = wb_valid_q;
  assign o_wb_rd                = wb_rd_q;
  assign o_wb_data              = wb_data_q;
  assign o_outstanding          = count_q;
  assign o_idle                 = !cmd_valid_q && (count_q == 5'd0) && !i_busy;
  assign o_err_unexpected       = err_q;

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Directed self-checking bench for rocc_cmd_issuer (TIMEOUT_CYCLES=16).
module tb_rocc_cmd_issuer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [6:0]  i_req_funct = 7'd0;
  logic [63:0] i_req_rs1 = 64'd0;
  logic [63:0] i_req_rs2 = 64'd0;
  logic        i_req_xs1 = 1'b0;
  logic        i_req_xs2 = 1'b0;
  logic [4:0]  i_req_rd = 5'd0;
  logic        i_req_xd = 1'b0;
  logic        o_cmd_valid;
  logic        i_cmd_ready = 1'b0;
  logic [6:0]  o_cmd_bits_inst_opcode;
  logic [6:0]  o_cmd_bits_inst_funct;
  logic [63:0] o_cmd_bits_rs1;
  logic [63:0] o_cmd_bits_rs2;
  logic        o_cmd_bits_inst_xs1;
  logic        o_cmd_bits_inst_xs2;
  logic [4:0]  o_cmd_bits_inst_rd;
  logic        o_cmd_bits_inst_xd;
  logic        o_cmd_fire;
  logic        i_busy = 1'b0;
  logic        i_resp_valid = 1'b0;
  logic        o_resp_ready;
  logic [4:0]  i_resp_bits_rd = 5'd0;
  logic [63:0] i_resp_bits_data = 64'd0;
  logic        o_resp_fire;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [63:0] o_wb_data;
  logic [4:0]  o_outstanding;
  logic        o_idle;
  logic        o_err_unexpected;
  logic        o_timeout;

  int vectors = 0;
  int miscompares = 0;

  rocc_cmd_issuer #(
    .OPCODE(7'b0001011), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_funct(i_req_funct), .i_req_rs1(i_req_rs1), .i_req_rs2(i_req_rs2),
    .i_req_xs1(i_req_xs1), .i_req_xs2(i_req_xs2), .i_req_rd(i_req_rd), .i_req_xd(i_req_xd),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_bits_inst_opcode(o_cmd_bits_inst_opcode), .o_cmd_bits_inst_funct(o_cmd_bits_inst_funct),
    .o_cmd_bits_rs1(o_cmd_bits_rs1), .o_cmd_bits_rs2(o_cmd_bits_rs2),
    .o_cmd_bits_inst_xs1(o_cmd_bits_inst_xs1), .o_cmd_bits_inst_xs2(o_cmd_bits_inst_xs2),
    .o_cmd_bits_inst_rd(o_cmd_bits_inst_rd), .o_cmd_bits_inst_xd(o_cmd_bits_inst_xd),
    .o_cmd_fire(o_cmd_fire), .i_busy(i_busy),
    .i_resp_valid(i_resp_valid), .o_resp_ready(o_resp_ready),
    .i_resp_bits_rd(i_resp_bits_rd), .i_resp_bits_data(i_resp_bits_data),
    .o_resp_fire(o_resp_fire), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_outstanding(o_outstanding), .o_idle(o_idle),
    .o_err_unexpected(o_err_unexpected), .o_timeout(o_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, need finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept then fire one command (assumes i_cmd_ready=1 and no hazard).
  task automatic issue(input logic [4:0] rd, input logic xd, input logic [6:0] funct);
    i_req_rd = rd; i_req_xd = xd; i_req_funct = funct;
    i_req_rs1 = 64'd0; i_req_rs2 = 64'd0; i_req_xs1 = 1'b0; i_req_xs2 = 1'b0;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
    tick();
  endtask

  // One response cycle; on return the writeback stage shows its result.
  task automatic respond(input logic [4:0] rd, input logic [63:0] data);
    i_resp_bits_rd = rd; i_resp_bits_data = data; i_resp_valid = 1'b1;
    tick();
    i_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    vectors++; if (o_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready got %b need 0", o_req_ready); end
    vectors++; if (o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_valid got %b need 0", o_cmd_valid); end
    vectors++; if (o_cmd_bits_inst_opcode !== 7'h0B) begin miscompares++; $display("FAIL rst_opcode got %h need 0b", o_cmd_bits_inst_opcode); end
    vectors++; if ({o_cmd_bits_inst_funct, o_cmd_bits_rs1, o_cmd_bits_inst_rd, o_cmd_bits_inst_xd} !== 77'd0) begin miscompares++; $display("FAIL rst_cmd_bits got nonzero need 0"); end
    vectors++; if (o_resp_ready !== 1'b0) begin miscompares++; $display("FAIL rst_resp_ready got %b need 0", o_resp_ready); end
    vectors++; if ({o_wb_valid, o_wb_rd, o_wb_data} !== 70'd0) begin miscompares++; $display("FAIL rst_wb got nonzero need 0"); end
    vectors++; if (o_outstanding !== 5'd0) begin miscompares++; $display("FAIL rst_outstanding got %0d need 0", o_outstanding); end
    vectors++; if ({o_err_unexpected, o_timeout} !== 2'b00) begin miscompares++; $display("FAIL rst_flags got %b need 00", {o_err_unexpected, o_timeout}); end
    vectors++; if (o_idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle got %b need 1", o_idle); end
    i_busy = 1'b1; #1;
    vectors++; if (o_idle !== 1'b0) begin miscompares++; $display("FAIL rst_idle_busy got %b need 0", o_idle); end
    i_busy = 1'b0;
    tick();
    reset = 1'b0; #1;
    vectors++; if (o_req_ready !== 1'b1 || o_resp_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got %b%b need 11", o_req_ready, o_resp_ready); end
  endtask

  task automatic test_basic();
    i_cmd_ready = 1'b1;
    i_req_funct = 7'd3; i_req_rs1 = 64'd5; i_req_rs2 = 64'd7; i_req_xs1 = 1'b1; i_req_xs2 = 1'b1;
    i_req_rd = 5'd10; i_req_xd = 1'b1; i_req_valid = 1'b1;
    #1;
    vectors++; if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL basic_req_ready got %b need 1", o_req_ready); end
    tick();
    i_req_valid = 1'b0; #1;
    vectors++; if (o_cmd_valid !== 1'b1 || o_cmd_fire !== 1'b1) begin miscompares++; $display("FAIL basic_cmd_valid got %b/%b need 1/1", o_cmd_valid, o_cmd_fire); end
    vectors++; if (o_cmd_bits_inst_funct !== 7'd3 || o_cmd_bits_rs1 !== 64'd5 || o_cmd_bits_rs2 !== 64'd7 || o_cmd_bits_inst_rd !== 5'd10) begin
      miscompares++; $display("FAIL basic_fields got f=%0d rs1=%0d rs2=%0d rd=%0d need 3/5/7/10", o_cmd_bits_inst_funct, o_cmd_bits_rs1, o_cmd_bits_rs2, o_cmd_bits_inst_rd); end
    vectors++; if ({o_cmd_bits_inst_xs1, o_cmd_bits_inst_xs2, o_cmd_bits_inst_xd} !== 3'b111 || o_cmd_bits_inst_opcode !== 7'h0B) begin
      miscompares++; $display("FAIL basic_flags got %b op=%h need 111 op=0b", {o_cmd_bits_inst_xs1, o_cmd_bits_inst_xs2, o_cmd_bits_inst_xd}, o_cmd_bits_inst_opcode); end
    tick();
    vectors++; if (o_outstanding !== 5'd1 || o_cmd_valid !== 1'b0 || o_idle !== 1'b0) begin
      miscompares++; $display("FAIL basic_after_fire got cnt=%0d v=%b idle=%b need 1/0/0", o_outstanding, o_cmd_valid, o_idle); end
    i_resp_bits_rd = 5'd10; i_resp_bits_data = 64'd12; i_resp_valid = 1'b1; #1;
    vectors++; if (o_resp_fire !== 1'b1) begin miscompares++; $display("FAIL basic_resp_fire got %b need 1", o_resp_fire); end
    tick();
    i_resp_valid = 1'b0;
    vectors++; if (o_wb_valid !== 1'b1 || o_wb_rd !== 5'd10 || o_wb_data !== 64'd12) begin
      miscompares++; $display("FAIL basic_wb got v=%b rd=%0d d=%0d need 1/10/12", o_wb_valid, o_wb_rd, o_wb_data); end
    vectors++; if (o_outstanding !== 5'd0 || o_idle !== 1'b1) begin miscompares++; $display("FAIL basic_idle got cnt=%0d idle=%b need 0/1", o_outstanding, o_idle); end
    tick();
    vectors++; if (o_wb_valid !== 1'b0) begin miscompares++; $display("FAIL basic_wb_pulse got %b need 0", o_wb_valid); end
  endtask

  task automatic test_stall();
    i_cmd_ready = 1'b0;
    i_req_funct = 7'h55; i_req_rs1 = 64'hDEAD_BEEF_0123_4567; i_req_rs2 = 64'h1111; i_req_rd = 5'd5; i_req_xd = 1'b0;
    i_req_valid = 1'b1;
    tick();
    // Present a different request while the held one waits.
    i_req_funct = 7'h22; i_req_rs1 = 64'd99; i_req_rd = 5'd6;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if (o_cmd_valid !== 1'b1 || o_cmd_fire !== 1'b0 || o_req_ready !== 1'b0) begin
        miscompares++; $display("FAIL stall_hs[%0d] got v=%b f=%b r=%b need 1/0/0", i, o_cmd_valid, o_cmd_fire, o_req_ready); end
      vectors++; if (o_cmd_bits_inst_funct !== 7'h55 || o_cmd_bits_rs1 !== 64'hDEAD_BEEF_0123_4567 || o_cmd_bits_inst_rd !== 5'd5) begin
        miscompares++; $display("FAIL stall_fields[%0d] got f=%h rs1=%h rd=%0d need 55/deadbeef01234567/5", i, o_cmd_bits_inst_funct, o_cmd_bits_rs1, o_cmd_bits_inst_rd); end
      tick();
    end
    i_req_valid = 1'b0; i_cmd_ready = 1'b1; #1;
    vectors++; if (o_cmd_fire !== 1'b1) begin miscompares++; $display("FAIL stall_fire got %b need 1", o_cmd_fire); end
    tick();
    vectors++; if (o_cmd_valid !== 1'b0 || o_outstanding !== 5'd0) begin miscompares++; $display("FAIL stall_after got v=%b cnt=%0d need 0/0", o_cmd_valid, o_outstanding); end
  endtask

  task automatic test_hazard();
    issue(5'd3, 1'b1, 7'd1);
    i_req_rd = 5'd3; i_req_xd = 1'b1; i_req_valid = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (o_req_ready !== 1'b0 || o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL hazard_block[%0d] got r=%b v=%b need 0/0", i, o_req_ready, o_cmd_valid); end
      tick();
    end
    i_resp_bits_rd = 5'd3; i_resp_bits_data = 64'd33; i_resp_valid = 1'b1; #1;
    vectors++; if (o_req_ready !== 1'b0) begin miscompares++; $display("FAIL hazard_no_bypass got %b need 0", o_req_ready); end
    tick();
    i_resp_valid = 1'b0; #1;
    vectors++; if (o_req_ready !== 1'b1 || o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL hazard_release got r=%b v=%b need 1/0", o_req_ready, o_cmd_valid); end
    tick();
    i_req_valid = 1'b0;
    vectors++; if (o_cmd_valid !== 1'b1 || o_cmd_bits_inst_rd !== 5'd3) begin miscompares++; $display("FAIL hazard_accept got v=%b rd=%0d need 1/3", o_cmd_valid, o_cmd_bits_inst_rd); end
    tick();
    respond(5'd3, 64'd34);
    tick();
    vectors++; if (o_outstanding !== 5'd0) begin miscompares++; $display("FAIL hazard_drain got %0d need 0", o_outstanding); end
  endtask

  task automatic test_max_outstanding();
    for (int r = 1; r <= 4; r++) issue(5'(r), 1'b1, 7'd2);
    vectors++; if (o_outstanding !== 5'd4) begin miscompares++; $display("FAIL max_count got %0d need 4", o_outstanding); end
    i_req_rd = 5'd5; i_req_xd = 1'b1; i_req_valid = 1'b1; #1;
    vectors++; if (o_req_ready !== 1'b0) begin miscompares++; $display("FAIL max_stall got %b need 0", o_req_ready); end
    tick();
    vectors++; if (o_req_ready !== 1'b0 || o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL max_stall2 got r=%b v=%b need 0/0", o_req_ready, o_cmd_valid); end
    i_req_xd = 1'b0; #1;
    vectors++; if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL max_xd0_ready got %b need 1", o_req_ready); end
    tick();
    i_req_valid = 1'b0;
    vectors++; if (o_cmd_valid !== 1'b1 || o_cmd_bits_inst_xd !== 1'b0 || o_cmd_bits_inst_rd !== 5'd5) begin
      miscompares++; $display("FAIL max_xd0_cmd got v=%b xd=%b rd=%0d need 1/0/5", o_cmd_valid, o_cmd_bits_inst_xd, o_cmd_bits_inst_rd); end
    tick();
    vectors++; if (o_outstanding !== 5'd4) begin miscompares++; $display("FAIL max_xd0_count got %0d need 4", o_outstanding); end
    i_req_rd = 5'd6; i_req_xd = 1'b1; i_req_valid = 1'b1;
    respond(5'd2, 64'd102); #1;
    vectors++; if (o_outstanding !== 5'd3 || o_wb_rd !== 5'd2 || o_req_ready !== 1'b1) begin
      miscompares++; $display("FAIL max_unblock got cnt=%0d wbrd=%0d r=%b need 3/2/1", o_outstanding, o_wb_rd, o_req_ready); end
    tick();
    i_req_valid = 1'b0;
    // Command fire and response fire in the same cycle: count stays at 3.
    respond(5'd1, 64'd101);
    vectors++; if (o_outstanding !== 5'd3 || o_wb_valid !== 1'b1 || o_wb_rd !== 5'd1 || o_wb_data !== 64'd101) begin
      miscompares++; $display("FAIL max_simul got cnt=%0d wb=%b rd=%0d d=%0d need 3/1/1/101", o_outstanding, o_wb_valid, o_wb_rd, o_wb_data); end
    respond(5'd3, 64'd103);
    respond(5'd4, 64'd104);
    respond(5'd6, 64'd106);
    vectors++; if (o_outstanding !== 5'd0 || o_wb_rd !== 5'd6 || o_err_unexpected !== 1'b0) begin
      miscompares++; $display("FAIL max_drain got cnt=%0d rd=%0d err=%b need 0/6/0", o_outstanding, o_wb_rd, o_err_unexpected); end
  endtask

  task automatic test_unexpected_and_rd0();
    issue(5'd0, 1'b1, 7'd4);
    vectors++; if (o_outstanding !== 5'd1) begin miscompares++; $display("FAIL rd0_count got %0d need 1", o_outstanding); end
    respond(5'd0, 64'h0000_0000_0000_ABCD);
    vectors++; if (o_wb_valid !== 1'b1 || o_wb_rd !== 5'd0 || o_wb_data !== 64'hABCD || o_outstanding !== 5'd0) begin
      miscompares++; $display("FAIL rd0_wb got v=%b rd=%0d d=%h cnt=%0d need 1/0/abcd/0", o_wb_valid, o_wb_rd, o_wb_data, o_outstanding); end
    respond(5'd9, 64'd9);
    vectors++; if (o_err_unexpected !== 1'b1 || o_wb_valid !== 1'b0 || o_outstanding !== 5'd0) begin
      miscompares++; $display("FAIL unexp got err=%b wb=%b cnt=%0d need 1/0/0", o_err_unexpected, o_wb_valid, o_outstanding); end
    tick(); tick();
    vectors++; if (o_err_unexpected !== 1'b1) begin miscompares++; $display("FAIL unexp_sticky got %b need 1", o_err_unexpected); end
  endtask

  task automatic test_reset_mid_op();
    issue(5'd7, 1'b1, 7'd5);
    i_cmd_ready = 1'b0;
    i_req_rd = 5'd8; i_req_xd = 1'b0; i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
    vectors++; if (o_cmd_valid !== 1'b1 || o_outstanding !== 5'd1) begin miscompares++; $display("FAIL mid_pre got v=%b cnt=%0d need 1/1", o_cmd_valid, o_outstanding); end
    #2 reset = 1'b1; #1;
    vectors++; if (o_cmd_valid !== 1'b0 || o_outstanding !== 5'd0 || o_err_unexpected !== 1'b0) begin
      miscompares++; $display("FAIL mid_async got v=%b cnt=%0d err=%b need 0/0/0", o_cmd_valid, o_outstanding, o_err_unexpected); end
    vectors++; if (o_req_ready !== 1'b0 || o_resp_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready got %b%b need 00", o_req_ready, o_resp_ready); end
    tick();
    reset = 1'b0; i_cmd_ready = 1'b1;
    // Scoreboard was wiped, so the old rd now counts as unexpected.
    respond(5'd7, 64'd7);
    vectors++; if (o_err_unexpected !== 1'b1 || o_wb_valid !== 1'b0) begin miscompares++; $display("FAIL mid_cleared got err=%b wb=%b need 1/0", o_err_unexpected, o_wb_valid); end
    reset = 1'b1; #1;
    vectors++; if (o_err_unexpected !== 1'b0) begin miscompares++; $display("FAIL err_reset got %b need 0", o_err_unexpected); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    logic exp_to;
`ifdef ROCC_ISSUER_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    issue(5'd11, 1'b1, 7'd6);
    for (int i = 0; i < 10; i++) tick();
    vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_early got %b need 0", o_timeout); end
    for (int i = 0; i < 12; i++) tick();
    vectors++; if (o_timeout !== exp_to) begin miscompares++; $display("FAIL timeout_late got %b need %b", o_timeout, exp_to); end
    respond(5'd11, 64'd11);
    tick();
    vectors++; if (o_timeout !== exp_to || o_outstanding !== 5'd0) begin miscompares++; $display("FAIL timeout_sticky got %b cnt=%0d need %b/0", o_timeout, o_outstanding, exp_to); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hazard();
    test_max_outstanding();
    test_unexpected_and_rd0();
    test_reset_mid_op();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rocc_cmd_issuer.md
# rocc_cmd_issuer

Core-side initiator for the custom RoCC command/response interface: accepts instruction requests from a host-side sequencer, drives them onto the accelerator's command channel, tracks outstanding destination registers in a 32-entry scoreboard, and returns response data as single-cycle writebacks. It sits between the test/host sequencer and any accelerator built on the RoCC command/response port set, and acts as the core end of that protocol.

## Interface
- OPCODE, 7'b0001011, opcode driven on every command (custom-0)
- MAX_OUTSTANDING, 4, maximum in-flight commands with xd=1 (1..31)
- TIMEOUT_CYCLES, 1024, response watchdog limit (used only with timeout enabled)

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- i_req_valid  in  1  host request valid
- o_req_ready  out  1  host request accepted when valid&&ready
- i_req_funct  in  7  funct7
- i_req_rs1 / i_req_rs2  in  64 each  operand data
- i_req_xs1 / i_req_xs2  in  1 each  operand enables
- i_req_rd  in  5  destination register
- i_req_xd  in  1  response expected
- o_cmd_valid  out  1  command valid to accelerator
- i_cmd_ready  in  1  accelerator ready
- o_cmd_bits_inst_opcode  out  7  = OPCODE
- o_cmd_bits_inst_funct, o_cmd_bits_rs1, o_cmd_bits_rs2, o_cmd_bits_inst_xs1, o_cmd_bits_inst_xs2, o_cmd_bits_inst_rd, o_cmd_bits_inst_xd  out  7/64/64/1/1/5/1  registered request fields
- o_cmd_fire  out  1  o_cmd_valid && i_cmd_ready
- i_busy  in  1  accelerator busy
- i_resp_valid  in  1  response valid
- o_resp_ready  out  1  response ready
- i_resp_bits_rd  in  5  response destination
- i_resp_bits_data  in  64  response data
- o_resp_fire  out  1  i_resp_valid && o_resp_ready
- o_wb_valid  out  1  writeback strobe, one cycle
- o_wb_rd  out  5  writeback register
- o_wb_data  out  64  writeback data
- o_outstanding  out  5  in-flight xd commands
- o_idle  out  1  no held command, o_outstanding==0, !i_busy
- o_err_unexpected  out  1  sticky: response to non-pending rd
- o_timeout  out  1  sticky watchdog flag

## Operation
- Command register: one entry. o_req_ready = !o_cmd_valid && !hazard. On acceptance fields captured; o_cmd_valid set next cycle, held with fields stable until o_cmd_fire.
- hazard = (i_req_xd && pending[i_req_rd]) || (i_req_xd && o_outstanding==MAX_OUTSTANDING). Evaluated on registered pending/count only; no same-cycle bypass of a response clearing the bit.
- On o_cmd_fire with xd=1: pending[rd] set, count +1. xd=0: no tracking.
- o_resp_ready = 1 whenever not in reset. On o_resp_fire: if pending[rd], clear it, count -1, next cycle o_wb_valid=1 with rd/data; else set o_err_unexpected, no writeback, count unchanged.
- Simultaneous cmd fire and resp fire: count changes by (+1 cmd xd) + (−1 valid resp); both pending updates apply; same rd impossible (hazard).
- rd=0 tracked like any other register.
- o_err_unexpected and o_timeout cleared only by reset.

## Timing
- Reset values: o_req_ready 0 during reset (1 after, if no hazard), o_cmd_valid 0, all cmd bits 0 except opcode = OPCODE, o_resp_ready 0, o_wb_valid 0, o_wb_rd 0, o_wb_data 0, o_outstanding 0, o_err_unexpected 0, o_timeout 0, o_idle follows !i_busy.
- Request accept → o_cmd_valid: 1 cycle. Back-to-back issue: every 2 cycles max (register empties on fire cycle, accepts next cycle).
- Response fire → o_wb_valid: 1 cycle, registered.
- Reset mid-operation: held command dropped, scoreboard and count cleared immediately (asynchronous).

## Configuration
- ROCC_ISSUER_TIMEOUT_EN defined: watchdog counter, width $clog2(TIMEOUT_CYCLES+1); cleared on any o_resp_fire or when o_outstanding==0; else increments; on reaching TIMEOUT_CYCLES sets o_timeout.
- Undefined: counter absent, o_timeout tied 0; port list unchanged.

## Test plan
- Request funct=3, rs1=5, rs2=7, rd=10, xd=1, i_cmd_ready=1 -> o_cmd_valid next cycle with fields matching and opcode 0x0B; o_outstanding=1; response rd=10 data=12 -> o_wb_valid one cycle later, rd=10, data=12, o_outstanding=0, o_idle=1.
- i_cmd_ready=0 for 5 cycles -> o_cmd_valid and all fields held stable, o_req_ready=0, fire on 6th cycle.
- Issue rd=3 xd=1, then request rd=3 -> o_req_ready=0 until response rd=3 fires, accepted the cycle after.
- Issue 4 xd commands rd=1..4 (MAX_OUTSTANDING=4) -> 5th xd request stalls; xd=0 request still issues; response rd=2 unblocks.
- Response rd=9 with nothing pending -> o_err_unexpected=1 sticky, no o_wb_valid, count unchanged; reset clears it.
- ROCC_ISSUER_TIMEOUT_EN, TIMEOUT_CYCLES=16: issue xd command, never respond -> o_timeout=1 after 16 cycles; without macro stays 0.
